// File: rtl/timer_pkg.sv
// timer_pkg: shared state encodings, BCD limits and digit clamp for the countdown timer
package timer_pkg;
    typedef enum logic [2:0] {
        SETSEC  = 3'b001,
        SETMIN  = 3'b010,
        RUN     = 3'b011,
        STOP    = 3'b100,
        TIMESUP = 3'b101
    } state_e;
    localparam logic [3:0] SEC_UNITS_MAX = 4'd9;
    localparam logic [3:0] SEC_TENS_MAX  = 4'd5;
    function automatic logic [3:0] clamp(input logic [3:0] v, input logic [3:0] lim);
        return (v > lim) ? lim : v;
    endfunction
endpackage

// File: rtl/timer_prescaler.sv
// timer_prescaler: modulo-CYCLES counter; tick_o is high while the count sits on its last value
//   clk_i  : clock
//   rst_i  : synchronous active-high reset
//   clr_i  : synchronous clear (priority over en_i)
//   en_i   : advance the count this cycle
//   tick_o : count == CYCLES-1 (raw, the parent gates it with its own enable)
module timer_prescaler #(
    parameter int unsigned CYCLES = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic tick_o
);
    localparam int W = (CYCLES > 1) ? $clog2(CYCLES) : 1;
    localparam logic [W-1:0] LAST = W'(CYCLES - 1);
    logic [W-1:0] cnt_q;
    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) cnt_q <= '0;
        else if (en_i) cnt_q <= tick_o ? '0 : cnt_q + 1'b1;
    end
    assign tick_o = (cnt_q == LAST);
endmodule

// File: rtl/timer_ctrl_fsm.sv
// timer_ctrl_fsm: mm:ss countdown controller (SETSEC -> SETMIN -> RUN <-> STOP -> TIMESUP)
//   CLOCK_50 / reset        : clock, synchronous active-high reset
//   set_btn / run_btn       : active-high key levels, edge-detected here
//   sw_units / sw_tens      : switch value for the digit pair being set
//   unit_sec..tens_min      : registered BCD display digits
//   state / running / timesup / alarm_led : registered status
// Optional macro TIMER_BLINK_EN: alarm_led blinks with half-period BLINK_CYCLES in TIMESUP;
// otherwise alarm_led simply mirrors timesup.
module timer_ctrl_fsm
    import timer_pkg::*;
#(
    parameter int unsigned TICK_CYCLES  = 50_000_000,
    parameter int unsigned MIN_TENS_MAX = 9,
    parameter int unsigned BLINK_CYCLES = 12_500_000
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       set_btn,
    input  logic       run_btn,
    input  logic [3:0] sw_units,
    input  logic [3:0] sw_tens,
    output logic [3:0] unit_sec,
    output logic [3:0] tens_sec,
    output logic [3:0] unit_min,
    output logic [3:0] tens_min,
    output logic [2:0] state,
    output logic       running,
    output logic       timesup,
    output logic       alarm_led
);
    localparam logic [3:0] MIN_TENS_LIM = 4'(MIN_TENS_MAX);
    if (TICK_CYCLES < 2 || BLINK_CYCLES < 1 || MIN_TENS_MAX < 1 || MIN_TENS_MAX > 9) begin : g_bad_cfg
        $error("timer_ctrl_fsm: invalid parameter set");
    end
    logic [2:0] state_q, state_d;
    logic [3:0] us_q, ts_q, um_q, tm_q, us_d, ts_d, um_d, tm_d;
    logic [3:0] us_dec, ts_dec, um_dec, tm_dec;
    logic       set_q, run_q, running_q, timesup_q, alarm_q, alarm_d;
    logic       set_press, run_press, pre_tick, tick, b0, b1, b2, dec_zero, set_zero;
    assign set_press = set_btn & ~set_q;
    assign run_press = run_btn & ~run_q;
    assign tick      = (state_q == RUN) && pre_tick;
    // Held (not advanced) on the stop press so the partial second survives; on a tick the
    // counter still wraps so the resumed second starts from zero.
    timer_prescaler #(.CYCLES(TICK_CYCLES)) u_tick (
        .clk_i (CLOCK_50),
        .rst_i (reset),
        .clr_i (state_q == SETMIN && set_press),
        .en_i  (state_q == RUN && (!run_press || pre_tick)),
        .tick_o(pre_tick)
    );
    // BCD borrow chain
    assign b0       = (us_q == 4'd0);
    assign b1       = b0 && (ts_q == 4'd0);
    assign b2       = b1 && (um_q == 4'd0);
    assign us_dec   = b0 ? 4'd9 : us_q - 4'd1;
    assign ts_dec   = b0 ? ((ts_q == 4'd0) ? 4'd5 : ts_q - 4'd1) : ts_q;
    assign um_dec   = b1 ? ((um_q == 4'd0) ? 4'd9 : um_q - 4'd1) : um_q;
    assign tm_dec   = b2 ? tm_q - 4'd1 : tm_q;
    assign dec_zero = ({tm_dec, um_dec, ts_dec, us_dec} == 16'h0);
    assign set_zero = ({tm_d, um_d, ts_d, us_d} == 16'h0);
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q   <= SETSEC;
            {tm_q, um_q, ts_q, us_q} <= '0;
            set_q     <= 1'b1;
            run_q     <= 1'b1;
            running_q <= 1'b0;
            timesup_q <= 1'b0;
            alarm_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            {tm_q, um_q, ts_q, us_q} <= {tm_d, um_d, ts_d, us_d};
            set_q     <= set_btn;
            run_q     <= run_btn;
            running_q <= (state_d == RUN);
            timesup_q <= (state_d == TIMESUP);
            alarm_q   <= alarm_d;
        end
    end
    always_comb begin
        state_d = SETSEC;
        case (state_q)
            SETSEC:  state_d = set_press ? SETMIN : SETSEC;
            SETMIN:  state_d = !set_press ? SETMIN : set_zero ? TIMESUP : RUN;
            RUN:     state_d = (tick && dec_zero) ? TIMESUP : run_press ? STOP : RUN;
            STOP:    state_d = run_press ? RUN : STOP;
            TIMESUP: state_d = TIMESUP;
            default: state_d = SETSEC;
        endcase
    end
    always_comb begin
        us_d = (state_q == SETSEC) ? clamp(sw_units, SEC_UNITS_MAX) : tick ? us_dec : us_q;
        ts_d = (state_q == SETSEC) ? clamp(sw_tens, SEC_TENS_MAX) : tick ? ts_dec : ts_q;
        um_d = (state_q == SETMIN) ? clamp(sw_units, SEC_UNITS_MAX) : tick ? um_dec : um_q;
        tm_d = (state_q == SETMIN) ? clamp(sw_tens, MIN_TENS_LIM) : tick ? tm_dec : tm_q;
    end
`ifdef TIMER_BLINK_EN
    logic blink_tick;
    timer_prescaler #(.CYCLES(BLINK_CYCLES)) u_blink (
        .clk_i (CLOCK_50),
        .rst_i (reset),
        .clr_i (state_q != TIMESUP),
        .en_i  (state_q == TIMESUP),
        .tick_o(blink_tick)
    );
    assign alarm_d = (state_d != TIMESUP) ? 1'b0 : (state_q != TIMESUP) ? 1'b1 : alarm_q ^ blink_tick;
`else
    assign alarm_d = (state_d == TIMESUP);
`endif
    assign {unit_sec, tens_sec, unit_min, tens_min} = {us_q, ts_q, um_q, tm_q};
    assign state     = state_q;
    assign running   = running_q;
    assign timesup   = timesup_q;
    assign alarm_led = alarm_q;
endmodule

// File: tb/tb_timer_ctrl_fsm.sv
// tb_timer_ctrl_fsm: directed self-checking bench for timer_ctrl_fsm (TICK_CYCLES=4, BLINK_CYCLES=2)
module tb_timer_ctrl_fsm;
    logic       clk = 1'b0;
    logic       reset = 1'b1, set_btn = 1'b0, run_btn = 1'b0;
    logic [3:0] sw_units = 4'd0, sw_tens = 4'd0;
    logic [3:0] unit_sec, tens_sec, unit_min, tens_min;
    logic [2:0] state;
    logic       running, timesup, alarm_led;
    logic [15:0] disp;
    int checks = 0, errors = 0;
    assign disp = {tens_min, unit_min, tens_sec, unit_sec};
    timer_ctrl_fsm #(.TICK_CYCLES(4), .MIN_TENS_MAX(9), .BLINK_CYCLES(2)) dut (
        .CLOCK_50(clk), .reset(reset), .set_btn(set_btn), .run_btn(run_btn),
        .sw_units(sw_units), .sw_tens(sw_tens),
        .unit_sec(unit_sec), .tens_sec(tens_sec), .unit_min(unit_min), .tens_min(tens_min),
        .state(state), .running(running), .timesup(timesup), .alarm_led(alarm_led)
    );
    always #5 clk = ~clk;
`ifdef TIMER_BLINK_EN
    localparam bit BLINK = 1'b1;
`else
    localparam bit BLINK = 1'b0;
`endif

    task automatic cyc(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic do_reset();
        set_btn = 1'b0; run_btn = 1'b0; sw_units = 4'd0; sw_tens = 4'd0;
        reset = 1'b1; cyc(1); reset = 1'b0; cyc(1);
    endtask

    // Leaves the bench one cycle after the edge that left SETMIN (prescaler at 0 if in RUN).
    task automatic load(input logic [3:0] mt, input logic [3:0] mu, input logic [3:0] st, input logic [3:0] su);
        sw_tens = st; sw_units = su; set_btn = 1'b1; cyc(1); set_btn = 1'b0; cyc(1);
        sw_tens = mt; sw_units = mu; set_btn = 1'b1; cyc(1); set_btn = 1'b0;
    endtask

    task automatic test_reset();
        sw_units = 4'd3; sw_tens = 4'd2; reset = 1'b1; cyc(2);
        checks++; if (state !== 3'b001) begin errors++; $display("FAIL reset_state got %b exp 001", state); end
        checks++; if (disp !== 16'h0000) begin errors++; $display("FAIL reset_disp got %h exp 0000", disp); end
        checks++; if ({running, timesup, alarm_led} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b exp 000", {running, timesup, alarm_led}); end
        reset = 1'b0;
    endtask

    task automatic test_set_run();
        do_reset(); load(4'd0, 4'd1, 4'd4, 4'd5);
        checks++; if (state !== 3'b011) begin errors++; $display("FAIL run_state got %b exp 011", state); end
        checks++; if (running !== 1'b1) begin errors++; $display("FAIL run_flag got %b exp 1", running); end
        checks++; if (disp !== 16'h0145) begin errors++; $display("FAIL run_load got %h exp 0145", disp); end
        cyc(3);
        checks++; if (disp !== 16'h0145) begin errors++; $display("FAIL run_pre_tick got %h exp 0145", disp); end
        cyc(1);
        checks++; if (disp !== 16'h0144) begin errors++; $display("FAIL run_first_tick got %h exp 0144", disp); end
    endtask

    task automatic test_borrow();
        do_reset(); load(4'd1, 4'd0, 4'd0, 4'd0); cyc(4);
        checks++; if (disp !== 16'h0959) begin errors++; $display("FAIL borrow_chain got %h exp 0959", disp); end
        cyc(59 * 4);
        checks++; if (disp !== 16'h0900) begin errors++; $display("FAIL borrow_59 got %h exp 0900", disp); end
    endtask

    task automatic test_clamp();
        do_reset(); sw_units = 4'd12; sw_tens = 4'd7; cyc(1);
        checks++; if (disp[7:0] !== 8'h59) begin errors++; $display("FAIL clamp_sec got %h exp 59", disp[7:0]); end
        set_btn = 1'b1; cyc(1); set_btn = 1'b0; sw_tens = 4'd15; sw_units = 4'd3; cyc(1);
        checks++; if (state !== 3'b010) begin errors++; $display("FAIL clamp_state got %b exp 010", state); end
        checks++; if (disp !== 16'h9359) begin errors++; $display("FAIL clamp_min got %h exp 9359", disp); end
        sw_units = 4'd14; cyc(1);
        checks++; if (disp !== 16'h9959) begin errors++; $display("FAIL clamp_min_units got %h exp 9959", disp); end
    endtask

    task automatic test_stop_resume();
        do_reset(); load(4'd0, 4'd1, 4'd4, 4'd5); cyc(2);
        run_btn = 1'b1; cyc(1); run_btn = 1'b0;
        checks++; if (state !== 3'b100) begin errors++; $display("FAIL stop_state got %b exp 100", state); end
        set_btn = 1'b1; cyc(1); set_btn = 1'b0; cyc(19);
        checks++; if (state !== 3'b100) begin errors++; $display("FAIL stop_set_ignored got %b exp 100", state); end
        checks++; if (disp !== 16'h0145) begin errors++; $display("FAIL stop_frozen got %h exp 0145", disp); end
        run_btn = 1'b1; cyc(1); run_btn = 1'b0;
        checks++; if (state !== 3'b011) begin errors++; $display("FAIL resume_state got %b exp 011", state); end
        cyc(1);
        checks++; if (disp !== 16'h0145) begin errors++; $display("FAIL resume_early got %h exp 0145", disp); end
        cyc(1);
        checks++; if (disp !== 16'h0144) begin errors++; $display("FAIL resume_tick got %h exp 0144", disp); end
    endtask

    task automatic test_expiry();
        do_reset(); load(4'd0, 4'd0, 4'd0, 4'd2); cyc(7);
        checks++; if (disp !== 16'h0001 || state !== 3'b011) begin errors++; $display("FAIL expiry_mid got %h/%b exp 0001/011", disp, state); end
        cyc(1);
        checks++; if (disp !== 16'h0000 || state !== 3'b101) begin errors++; $display("FAIL expiry_zero got %h/%b exp 0000/101", disp, state); end
        checks++; if ({running, timesup, alarm_led} !== 3'b011) begin errors++; $display("FAIL expiry_flags got %b exp 011", {running, timesup, alarm_led}); end
        cyc(1);
        checks++; if (alarm_led !== 1'b1) begin errors++; $display("FAIL alarm_hold got %b exp 1", alarm_led); end
        cyc(1);
        checks++; if (alarm_led !== !BLINK) begin errors++; $display("FAIL alarm_toggle got %b exp %b", alarm_led, !BLINK); end
        cyc(2);
        checks++; if (alarm_led !== 1'b1) begin errors++; $display("FAIL alarm_back got %b exp 1", alarm_led); end
        run_btn = 1'b1; set_btn = 1'b1; cyc(1); run_btn = 1'b0; set_btn = 1'b0; cyc(1);
        checks++; if (state !== 3'b101 || disp !== 16'h0000) begin errors++; $display("FAIL expiry_ignore got %b/%h exp 101/0000", state, disp); end
        reset = 1'b1; cyc(1);
        checks++; if (state !== 3'b001 || disp !== 16'h0000 || {timesup, alarm_led} !== 2'b00) begin errors++; $display("FAIL expiry_reset got %b/%h/%b", state, disp, {timesup, alarm_led}); end
        reset = 1'b0;
    endtask

    task automatic test_held_through_reset();
        set_btn = 1'b1; reset = 1'b1; cyc(2); reset = 1'b0; cyc(3);
        checks++; if (state !== 3'b001) begin errors++; $display("FAIL held_no_act got %b exp 001", state); end
        set_btn = 1'b0; cyc(1);
        checks++; if (state !== 3'b001) begin errors++; $display("FAIL held_release got %b exp 001", state); end
        set_btn = 1'b1; cyc(1); set_btn = 1'b0;
        checks++; if (state !== 3'b010) begin errors++; $display("FAIL held_repress got %b exp 010", state); end
    endtask

    task automatic test_zero_setmin();
        do_reset(); load(4'd0, 4'd0, 4'd0, 4'd0);
        checks++; if (state !== 3'b101 || timesup !== 1'b1) begin errors++; $display("FAIL zero_direct got %b/%b exp 101/1", state, timesup); end
    endtask

    task automatic test_tick_press();
        do_reset(); load(4'd0, 4'd0, 4'd0, 4'd5); cyc(3);
        run_btn = 1'b1; cyc(1); run_btn = 1'b0;
        checks++; if (state !== 3'b100 || disp !== 16'h0004) begin errors++; $display("FAIL tick_stop got %b/%h exp 100/0004", state, disp); end
        do_reset(); load(4'd0, 4'd0, 4'd0, 4'd1); cyc(3);
        run_btn = 1'b1; cyc(1); run_btn = 1'b0;
        checks++; if (state !== 3'b101 || disp !== 16'h0000) begin errors++; $display("FAIL tick_zero_press got %b/%h exp 101/0000", state, disp); end
    endtask

    initial begin
        test_reset();
        test_set_run();
        test_borrow();
        test_clamp();
        test_stop_resume();
        test_expiry();
        test_held_through_reset();
        test_zero_setmin();
        test_tick_press();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
